wb_line_master: RTL and testbench
=================================

// Module: wb_line_master
// PURPOSE
//  Wishbone master that turns single cache-line read/write requests into one
//  bus transaction against the line-granular physical memory slave. Sits
//  between the cache (request/response handshake) and the wishbone bus.
//  Holds the bus stable until ACK, treats RTY as wait, and aborts on timeout.
// PARAMETERS
//  ADDR_W   16    byte-address width; line index is ADR[ADDR_W-1:4]
//  LINE_W   128   line/data width in bits (SEL width = LINE_W/8)
//  TIMEOUT  1024  max cycles in BUSY without ACK before abort (>=2)
//  GAP      1     idle cycles forced after each transaction before req_ready
// PORTS
//  clk         in   1        bus clock (drives wishbone CLK)
//  rst         in   1        synchronous, active-high reset
//  req_valid   in   1        cache requests a line transaction
//  req_ready   out  1        master can accept a request this cycle
//  req_we      in   1        1 = write line, 0 = read line
//  req_addr    in   ADDR_W   byte address; bits [3:0] ignored
//  req_wdata   in   LINE_W   write line data
//  resp_valid  out  1        one-cycle pulse: transaction finished
//  resp_rdata  out  LINE_W   read line data, valid with resp_valid
//  resp_err    out  1        with resp_valid: transaction timed out
//  wb_cyc      out  1        wishbone CYC
//  wb_stb      out  1        wishbone STB
//  wb_we       out  1        wishbone WE
//  wb_adr      out  ADDR_W   wishbone ADR, low 4 bits always 0
//  wb_dat_m    out  LINE_W   wishbone DAT_M (write data)
//  wb_sel      out  LINE_W/8 wishbone SEL, all ones while STB=1, else 0
//  wb_dat_s    in   LINE_W   wishbone DAT_S (read data, valid with ACK)
//  wb_ack      in   1        wishbone ACK, single-cycle
//  wb_rty      in   1        wishbone RTY, slave busy; not an error
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE, gap/timeout counters 0; all outputs 0
//   incl. req_ready, resp_*, wb_*. req_ready may rise the cycle after rst falls.
//  States: IDLE -> BUSY -> RESP -> GAP -> IDLE (GAP skipped when GAP=0).
//  IDLE: req_ready=1. Edge with req_valid&req_ready: latch we, addr with
//   [3:0]=0, wdata; -> BUSY. req_ready=0 in all other states.
//  BUSY: wb_cyc=wb_stb=1, wb_we/wb_adr/wb_dat_m/wb_sel constant for whole
//   state (slave drops the access if ADR changes). wb_rty ignored except as
//   wait. Timeout counter increments each BUSY cycle without ACK.
//  ACK seen in BUSY at edge K: capture wb_dat_s if read (rdata=0 if write);
//   -> RESP. From K+1: wb_cyc=wb_stb=0, resp_valid=1, resp_err=0 for one cycle.
//  Timeout: count reaches TIMEOUT-1 without ACK -> RESP with resp_err=1,
//   resp_rdata=0; bus deasserted same as ACK case. ACK on that same edge wins.
//  GAP: GAP cycles, all wb_* 0, req_ready=0; then IDLE. Guarantees STB low
//   >=1 cycle so the slave returns to its idle state.
//  wb_ack outside BUSY: ignored, no response, no state change.
//  resp_rdata/resp_err: held until next resp_valid; 0 after reset.
//  Latency: accept edge N -> STB high N+1..K -> resp_valid at K+1 ->
//   req_ready at K+2+GAP. Min request-to-response = 2 cycles.
//  rst mid-transaction: bus outputs 0 from next cycle, no resp_valid, latched
//   request discarded.
//  All outputs registered; no combinational path req_* or wb_* inputs to outputs.
// TESTING
//  1 Read: mem line 0x12 = 0xA5..A5; req read addr 0x012C -> wb_adr=0x0120,
//    WE=0, STB held till ACK; resp_valid 1 cycle, rdata=0xA5..A5, err=0.
//  2 Write then read: write 0xDEADBEEF_x4 to 0x0340, then read 0x0340 ->
//    rdata=0xDEADBEEF_x4; wb_dat_m/adr stable every BUSY cycle (assertion).
//  3 Slow slave (200-cycle delay, RTY high while busy): no error, one
//    resp_valid, STB never drops before ACK.
//  4 Timeout: TIMEOUT=16, slave never ACKs -> STB low after 16 BUSY cycles,
//    resp_valid=1, resp_err=1, rdata=0; next request completes normally.
//  5 rst asserted 5 cycles into BUSY -> wb_cyc/stb=0 next cycle, no
//    resp_valid; stray ACK afterwards ignored; new request succeeds.
//  6 Back-to-back: req_valid held high for 4 reqs -> 4 responses in order,
//    STB low >=GAP cycles between transactions, req_ready only in IDLE.

Source files
------------

// File: rtl/wb_line_master.sv
// rtl/wb_line_master.sv - Wishbone master issuing one line-wide read/write per cache request
module wb_line_master #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LINE_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [LINE_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic                wb_we,
    output logic [ADDR_W-1:0]   wb_adr,
    output logic [LINE_W-1:0]   wb_dat_m,
    output logic [LINE_W/8-1:0] wb_sel,
    input  logic [LINE_W-1:0]   wb_dat_s,
    input  logic                wb_ack,
    input  logic                wb_rty
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_GAP} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tmo_cnt, tmo_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] adr_nxt;
    logic [LINE_W-1:0] dat_nxt;
    logic              rvalid_nxt;
    logic [LINE_W-1:0] rdata_nxt;
    logic              err_nxt;
    logic              busy_nxt;

    // Line offset bits are dropped and RTY only means "keep waiting", so neither feeds any logic.
    logic unused_inputs;
    assign unused_inputs = ^{req_addr[3:0], wb_rty};

    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo_cnt;
        gap_nxt    = gap_cnt;
        we_nxt     = wb_we;
        adr_nxt    = wb_adr;
        dat_nxt    = wb_dat_m;
        rvalid_nxt = 1'b0;
        rdata_nxt  = resp_rdata;
        err_nxt    = resp_err;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = S_BUSY;
                    tmo_nxt   = '0;
                    we_nxt    = req_we;
                    adr_nxt   = {req_addr[ADDR_W-1:4], 4'b0000};
                    dat_nxt   = req_wdata;
                end
            end
            S_BUSY: begin
                // ACK on the final allowed cycle still completes the access normally.
                if (wb_ack) begin
                    state_nxt  = S_RESP;
                    rvalid_nxt = 1'b1;
                    rdata_nxt  = wb_we ? '0 : wb_dat_s;
                    err_nxt    = 1'b0;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_nxt  = S_RESP;
                    rvalid_nxt = 1'b1;
                    rdata_nxt  = '0;
                    err_nxt    = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            S_RESP: begin
                gap_nxt   = '0;
                state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt == S_BUSY);
    end

    // Bus outputs are registered from the next state so they are zero everywhere outside BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= '0;
            wb_dat_m   <= '0;
            wb_sel     <= '0;
        end else begin
            state      <= state_nxt;
            tmo_cnt    <= tmo_nxt;
            gap_cnt    <= gap_nxt;
            req_ready  <= (state_nxt == S_IDLE);
            resp_valid <= rvalid_nxt;
            resp_rdata <= rdata_nxt;
            resp_err   <= err_nxt;
            wb_cyc     <= busy_nxt;
            wb_stb     <= busy_nxt;
            wb_we      <= busy_nxt & we_nxt;
            wb_adr     <= busy_nxt ? adr_nxt : '0;
            wb_dat_m   <= busy_nxt ? dat_nxt : '0;
            wb_sel     <= {(LINE_W/8){busy_nxt}};
        end
    end
endmodule

// File: tb/tb_wb_line_master.sv
// tb/tb_wb_line_master.sv - randomized bench for wb_line_master against a line-memory model
module tb_wb_line_master;
    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 256;
    localparam int GAP     = 1;
    localparam int NLINES  = 1 << (ADDR_W - 4);

    typedef logic [LINE_W-1:0] line_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_we = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [LINE_W-1:0]   req_wdata = '0;
    logic                req_ready, resp_valid, resp_err;
    logic [LINE_W-1:0]   resp_rdata;
    logic                wb_cyc, wb_stb, wb_we;
    logic [ADDR_W-1:0]   wb_adr;
    logic [LINE_W-1:0]   wb_dat_m;
    logic [LINE_W/8-1:0] wb_sel;
    logic [LINE_W-1:0]   wb_dat_s = '0;
    logic                wb_ack;
    logic                wb_rty = 1'b0;
    logic                slv_ack = 1'b0;
    logic                stray_ack = 1'b0;

    assign wb_ack = slv_ack | stray_ack;

    always #5 clk = ~clk;

    wb_line_master #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_m(wb_dat_m), .wb_sel(wb_sel), .wb_dat_s(wb_dat_s),
        .wb_ack(wb_ack), .wb_rty(wb_rty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input line_t got, input line_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    line_t             mem     [NLINES];
    line_t             ref_mem [NLINES];
    logic [11:0]       lines   [8];
    logic [LINE_W:0]   exp_q   [$];
    int                low_runs[$];
    logic              exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_adr = '0;
    line_t             exp_wdata = '0;
    int                slave_delay = 0;
    bit                slave_never = 1'b0;
    bit                in_txn = 1'b0;
    bit                acked = 1'b0;
    int                remaining = 0;
    int                resp_count = 0;
    int                low_run = 0;
    bit                prev_stb = 1'b0;
    bit                prev_resp = 1'b0;
    bit                seen_fall = 1'b0;

    // Line-granular memory slave: ACK after slave_delay wait cycles, RTY while waiting.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_cyc && wb_stb) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    acked = 1'b0;
                    remaining = slave_delay;
                end
                if (!slave_never && !acked && remaining == 0) begin
                    slv_ack = 1'b1;
                    wb_rty = 1'b0;
                    acked = 1'b1;
                    if (wb_we) mem[wb_adr[ADDR_W-1:4]] = wb_dat_m;
                    else wb_dat_s = mem[wb_adr[ADDR_W-1:4]];
                end else begin
                    slv_ack = 1'b0;
                    wb_rty = 1'b1;
                    if (remaining > 0) remaining--;
                end
            end else begin
                in_txn = 1'b0;
                slv_ack = 1'b0;
                wb_rty = 1'b0;
            end
        end
    end

    function automatic logic [LINE_W:0] model(input logic we, input logic [ADDR_W-1:0] addr,
                                              input line_t wdata, input bit never);
        if (never) return {1'b1, line_t'(0)};
        if (we) begin
            ref_mem[addr[ADDR_W-1:4]] = wdata;
            return {1'b0, line_t'(0)};
        end
        return {1'b0, ref_mem[addr[ADDR_W-1:4]]};
    endfunction

    initial begin
        logic [LINE_W:0] e;
        forever begin
            @(negedge clk);
            check("sel", line_t'(wb_sel), line_t'({(LINE_W/8){wb_stb}}));
            check("cyc_stb", line_t'(wb_cyc), line_t'(wb_stb));
            check("ready_vs_stb", line_t'(req_ready & wb_stb), line_t'(0));
            if (wb_stb) begin
                if (!prev_stb && seen_fall) low_runs.push_back(low_run);
                check("adr", line_t'(wb_adr), line_t'(exp_adr));
                check("we", line_t'(wb_we), line_t'(exp_we));
                if (exp_we) check("dat_m", wb_dat_m, exp_wdata);
            end else begin
                if (prev_stb) begin
                    seen_fall = 1'b1;
                    low_run = 0;
                end
                low_run++;
            end
            if (resp_valid) begin
                resp_count++;
                check("resp_repeat", line_t'(prev_resp), line_t'(0));
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", line_t'(1), line_t'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e[LINE_W-1:0]);
                    check("resp_err", line_t'(resp_err), line_t'(e[LINE_W]));
                end
            end
            prev_stb = wb_stb;
            prev_resp = resp_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("ready_wait", line_t'(0), line_t'(1));
    endtask

    task automatic present(input logic we, input logic [ADDR_W-1:0] addr, input line_t wdata,
                           input bit never, input bit track);
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        exp_we = we;
        exp_adr = {addr[ADDR_W-1:4], 4'h0};
        exp_wdata = wdata;
        if (track) exp_q.push_back(model(we, addr, wdata, never));
    endtask

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input line_t wdata,
                          input int dly, input bit never);
        int lat = 1;
        int stb_cycles = 0;
        slave_delay = dly;
        slave_never = never;
        wait_ready();
        present(we, addr, wdata, never, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        while (!resp_valid && lat < TIMEOUT + 50) begin
            if (wb_stb) stb_cycles++;
            @(negedge clk);
            lat++;
        end
        check("latency", line_t'(lat), line_t'(never ? TIMEOUT + 1 : dly + 2));
        check("stb_cycles", line_t'(stb_cycles), line_t'(never ? TIMEOUT : dly + 1));
        @(negedge clk);
        check("resp_one_cycle", line_t'(resp_valid), line_t'(0));
        slave_never = 1'b0;
    endtask

    initial begin
        line_t v;
        int    n;
        int    k;
        int    start;
        for (int i = 0; i < NLINES; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[12'h012] = {16{8'hA5}};
        ref_mem[12'h012] = {16{8'hA5}};
        for (int i = 0; i < 8; i++) lines[i] = 12'($urandom);

        repeat (3) @(negedge clk);
        check("rst_ready", line_t'(req_ready), line_t'(0));
        check("rst_resp_valid", line_t'(resp_valid), line_t'(0));
        check("rst_cyc", line_t'(wb_cyc), line_t'(0));
        check("rst_stb", line_t'(wb_stb), line_t'(0));
        check("rst_we", line_t'(wb_we), line_t'(0));
        check("rst_adr", line_t'(wb_adr), line_t'(0));
        check("rst_dat_m", wb_dat_m, line_t'(0));
        check("rst_rdata", resp_rdata, line_t'(0));
        check("rst_err", line_t'(resp_err), line_t'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", line_t'(req_ready), line_t'(1));

        do_req(1'b0, 16'h012C, line_t'(0), 1, 1'b0);
        check("t1_rdata", resp_rdata, {16{8'hA5}});
        check("t1_err", line_t'(resp_err), line_t'(0));

        do_req(1'b1, 16'h0340, {4{32'hDEADBEEF}}, 0, 1'b0);
        check("t2_wdata_zero", resp_rdata, line_t'(0));
        do_req(1'b0, 16'h0340, line_t'(0), 3, 1'b0);
        check("t2_rdata", resp_rdata, {4{32'hDEADBEEF}});

        do_req(1'b0, 16'h0345, line_t'(0), 200, 1'b0);
        check("t3_err", line_t'(resp_err), line_t'(0));
        check("t3_rdata", resp_rdata, {4{32'hDEADBEEF}});

        v = {$urandom, $urandom, $urandom, $urandom};
        do_req(1'b1, 16'h0550, v, TIMEOUT - 1, 1'b0);
        check("last_cycle_ack_err", line_t'(resp_err), line_t'(0));

        do_req(1'b0, 16'h0770, line_t'(0), 0, 1'b1);
        check("t4_err", line_t'(resp_err), line_t'(1));
        check("t4_rdata", resp_rdata, line_t'(0));
        do_req(1'b0, 16'h055F, line_t'(0), 2, 1'b0);
        check("t4_recover", resp_rdata, v);
        check("t4_recover_err", line_t'(resp_err), line_t'(0));

        slave_never = 1'b1;
        wait_ready();
        present(1'b0, 16'h0120, line_t'(0), 1'b1, 1'b0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_busy", line_t'(wb_stb), line_t'(1));
        rst = 1'b1;
        @(negedge clk);
        check("t5_cyc", line_t'(wb_cyc), line_t'(0));
        check("t5_stb", line_t'(wb_stb), line_t'(0));
        check("t5_resp", line_t'(resp_valid), line_t'(0));
        check("t5_ready", line_t'(req_ready), line_t'(0));
        check("t5_rdata", resp_rdata, line_t'(0));
        rst = 1'b0;
        slave_never = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("t5_no_resp", line_t'(resp_valid), line_t'(0));
        end
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_no_resp", line_t'(resp_valid), line_t'(0));
            check("stray_ready", line_t'(req_ready), line_t'(1));
        end
        do_req(1'b0, 16'h0120, line_t'(0), 1, 1'b0);
        check("t5_after", resp_rdata, {16{8'hA5}});

        for (int t = 0; t < 30; t++) begin
            do_req(1'($urandom_range(0, 1)), {lines[$urandom_range(0, 7)], 4'($urandom)},
                   {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 6)), 1'b0);
        end

        slave_delay = int'($urandom_range(0, 3));
        low_runs.delete();
        start = resp_count;
        n = 0;
        k = 0;
        while (k < 4 && n < 500) begin
            @(negedge clk);
            n++;
            if (req_ready) begin
                present(1'($urandom_range(0, 1)), {lines[$urandom_range(0, 7)], 4'($urandom)},
                        {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
                k++;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (resp_count < start + 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("b2b_count", line_t'(resp_count - start), line_t'(4));
        check("b2b_runs", line_t'(low_runs.size()), line_t'(4));
        for (int i = 1; i < low_runs.size(); i++) check("b2b_stb_low", line_t'(low_runs[i]), line_t'(GAP + 2));
        check("pending_resp", line_t'(exp_q.size()), line_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
